// File: rtl/instr_fetch_if.sv
// Instruction-memory request/ready channel between the fetch stage and memory.
// The fetch side holds req with a stable address until ready is sampled high.
interface instr_fetch_if #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 8
);
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               imem_ready;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_ready
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_ready
    );
endinterface

// File: rtl/instr_fetch.sv
// Fetch stage: PC, one-entry fetch buffer and IR, feeding the CPU controller.
// Stalls with op=NOP until fetched data is available in the buffer.
module instr_fetch #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 8
) (
    input  logic              clk,
    input  logic              CLB,
    input  logic              LoadIR,
    input  logic              IncPC,
    input  logic              SelPC,
    input  logic              LoadPC,
    input  logic [ADDR_W-1:0] reg_target,
    instr_fetch_if.master     imem,
    output logic [3:0]        op,
    output logic [3:0]        operand,
    output logic              ir_valid,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_FULL  = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t             state_q;
    logic [ADDR_W-1:0]  pc_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [INSTR_W-1:0] ir_q;
    logic [INSTR_W-1:0] fbuf_q;
    logic               ir_valid_q;
    logic               req_q;

    logic [ADDR_W-1:0]  pc_inc;
    logic [ADDR_W-1:0]  jump_tgt;
    logic               mem_done;
    logic               req_wait;

    assign pc_inc   = pc_q + ADDR_W'(1);
    assign jump_tgt = SelPC ? reg_target
                            : ADDR_W'(ir_q[3:0]);
    assign mem_done = req_q & imem.imem_ready;
    assign req_wait = (state_q == S_REQ) & req_q
                    & ~imem.imem_ready;

    // fbuf is valid exactly while in S_FULL
    always_ff @(posedge clk or negedge CLB) begin
        if (!CLB) begin
            state_q    <= S_REQ;
            pc_q       <= '0;
            addr_q     <= '0;
            ir_q       <= '0;
            fbuf_q     <= '0;
            ir_valid_q <= 1'b0;
            req_q      <= 1'b0;
        end else if (LoadPC) begin
            pc_q       <= jump_tgt;
            ir_valid_q <= 1'b0;
            req_q      <= 1'b1;
            unique case (1'b1)
                state_q == S_FLUSH: begin
                    if (imem.imem_ready) begin
                        state_q <= S_REQ;
                        addr_q  <= jump_tgt;
                    end
                end
                req_wait: begin
                    state_q <= S_FLUSH;
                end
                default: begin
                    state_q <= S_REQ;
                    addr_q  <= jump_tgt;
                end
            endcase
        end else begin
            unique case (1'b1)
                state_q == S_FULL: begin
                    if (LoadIR) begin
                        ir_q       <= fbuf_q;
                        ir_valid_q <= 1'b1;
                    end
                    if (IncPC) begin
                        pc_q    <= pc_inc;
                        addr_q  <= pc_inc;
                        req_q   <= 1'b1;
                        state_q <= S_REQ;
                    end
                end
                state_q == S_FLUSH: begin
                    if (imem.imem_ready) begin
                        state_q <= S_REQ;
                        addr_q  <= pc_q;
                    end
                end
                default: begin
                    req_q   <= 1'b1;
                    state_q <= S_REQ;
                    if (mem_done) begin
                        fbuf_q  <= imem.imem_rdata;
                        req_q   <= 1'b0;
                        state_q <= S_FULL;
                    end
                end
            endcase
        end
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = addr_q;

    assign op       = ir_valid_q ? ir_q[INSTR_W-1 -: 4]
                                 : 4'b0000;
    assign operand  = ir_q[3:0];
    assign ir_valid = ir_valid_q;
    assign pc       = pc_q;
    assign halted   = ir_valid_q
                    & (ir_q[INSTR_W-1 -: 4] == 4'hF);

endmodule
